// File: rtl/instr_issuer_if.sv
// Pin-side program loader / run-control bundle plus the compute-unit issue port
// of instr_issuer. The master drives bytes and control; the slave is the issuer.
interface instr_issuer_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          start;
  logic          stop;
  logic          loop;
  logic          clear;
  logic [15:0]   instruction;
  logic          en;
  logic          busy;
  logic          done;
  logic [CW-1:0] prog_count;

  modport master (
    output byte_in, byte_valid, start, stop, loop, clear,
    input  byte_ready, instruction, en, busy, done, prog_count
  );

  modport slave (
    input  byte_in, byte_valid, start, stop, loop, clear,
    output byte_ready, instruction, en, busy, done, prog_count
  );
endinterface

// File: rtl/instr_issuer.sv
// Byte-wide program loader and instruction sequencer: packs byte pairs into 16-bit
// words, then issues them back-to-back to the compute unit on start, optionally looping.
module instr_issuer #(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  instr_issuer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state;
  logic          half;
  logic [7:0]    high;
  logic [AW-1:0] pc;
  logic [AW-1:0] nxt_pc;
  logic [CW-1:0] prog_count;
  logic [15:0]   mem [DEPTH];

  logic [15:0]   instruction_q;
  logic          en_q;
  logic          busy_q;
  logic          done_q;

  logic idle;
  logic run_ok;
  logic empty_start;
  logic clear_ok;
  logic byte_ready;
  logic byte_acc;
  logic last;

  assign idle        = (state == ST_IDLE);
  assign run_ok      = idle && bus.start && !half && (prog_count != '0);
  assign empty_start = idle && bus.start && !half && (prog_count == '0);
  assign clear_ok    = idle && bus.clear && !run_ok;
  // A byte offered in the cycle a run is launched must stay with the sender.
  assign byte_ready  = !rst && idle && (prog_count < CW'(DEPTH)) && !run_ok;
  assign byte_acc    = bus.byte_valid && byte_ready && !clear_ok;
  assign last        = ({1'b0, pc} == (prog_count - CW'(1)));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    nxt_pc = '0;
    if (state == ST_RUN && !last)
      nxt_pc = pc + AW'(1);
  end

  // NOTE: the program buffer and byte staging register have no reset; they are
  // pure datapath and are only meaningful once prog_count/half say so.
  always_ff @(posedge clk) begin
    if (byte_acc && !half)
      high <= bus.byte_in;
    if (byte_acc && half)
      mem[prog_count[AW-1:0]] <= {high, bus.byte_in};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      half          <= 1'b0;
      pc            <= '0;
      prog_count    <= '0;
      instruction_q <= '0;
      en_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear_ok) begin
            prog_count <= '0;
            half       <= 1'b0;
          end else if (byte_acc) begin
            half <= !half;
            if (half)
              prog_count <= prog_count + CW'(1);
          end
          if (run_ok) begin
            state         <= ST_RUN;
            pc            <= nxt_pc;
            instruction_q <= mem[nxt_pc];
            en_q          <= 1'b1;
            busy_q        <= 1'b1;
          end else if (empty_start) begin
            done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          // stop outranks both the wrap and the last-entry exit.
          if (bus.stop || (last && !bus.loop)) begin
            state         <= ST_IDLE;
            pc            <= '0;
            instruction_q <= '0;
            en_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
          end else begin
            pc            <= nxt_pc;
            instruction_q <= mem[nxt_pc];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.byte_ready  = byte_ready;
  assign bus.instruction = instruction_q;
  assign bus.en          = en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.prog_count  = prog_count;
endmodule
